// File: rtl/car_motion_sequencer.sv
// rtl/car_motion_sequencer.sv - prescaled speed integrator with standstill door-lock interlock
module car_motion_sequencer #(
   parameter logic [7:0] MAX_SPEED  = 8'd200,
   parameter logic [7:0] ACCEL_STEP = 8'd2,
   parameter logic [7:0] DECEL_STEP = 8'd3,
   parameter logic [7:0] TICK_DIV   = 8'd4,
   parameter logic [3:0] DOOR_DELAY = 4'd3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       accelerate_car,
   input  logic       unlock_doors,
   input  logic       door_closed,
   output logic [7:0] car_speed,
   output logic       speed_tick,
   output logic       doors_unlocked,
   output logic       motion_inhibit,
   output logic       door_alarm
);

   typedef enum logic [1:0] {
      S_LOCKED   = 2'd0,
      S_SETTLE   = 2'd1,
      S_UNLOCKED = 2'd2,
      S_RELOCK   = 2'd3
   } door_state_t;

   door_state_t r_state;
   door_state_t w_next;
   logic [7:0]  r_presc;
   logic [7:0]  r_speed;
   logic [7:0]  w_speed_next;
   logic [3:0]  r_settle;
   logic [3:0]  w_settle_next;
   logic        r_doors_unlocked;
   logic        w_tick;
   logic        w_standstill_req;
   logic [8:0]  w_sum;

   assign w_tick           = (r_presc == TICK_DIV - 8'd1);
   assign w_sum            = {1'b0, r_speed} + {1'b0, ACCEL_STEP};
   assign w_standstill_req = (r_speed == 8'd0) && unlock_doors && !accelerate_car;

   assign car_speed      = r_speed;
   assign speed_tick     = w_tick;
   assign doors_unlocked = r_doors_unlocked;

   // Sum is 9 bits so a step past 255 still clamps instead of wrapping.
   always_comb begin
      w_speed_next = r_speed;
      if (w_tick && !motion_inhibit) begin
         if (accelerate_car) begin
            w_speed_next = (w_sum > {1'b0, MAX_SPEED}) ? MAX_SPEED : w_sum[7:0];
         end else begin
            w_speed_next = (r_speed > DECEL_STEP) ? (r_speed - DECEL_STEP) : 8'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc          <= 8'd0;
         r_speed          <= 8'd0;
         r_state          <= S_LOCKED;
         r_settle         <= 4'd0;
         r_doors_unlocked <= 1'b0;
      end else begin
         r_presc          <= w_tick ? 8'd0 : r_presc + 8'd1;
         r_speed          <= w_speed_next;
         r_state          <= w_next;
         r_settle         <= w_settle_next;
         r_doors_unlocked <= (w_next == S_UNLOCKED);
      end
   end

   // Any break in the standstill request during SETTLE restarts the wait from LOCKED.
   always_comb begin
      w_next        = r_state;
      w_settle_next = r_settle;
      case (r_state)
         S_LOCKED: begin
            w_settle_next = 4'd0;
            if (w_standstill_req) begin
               w_next = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (!w_standstill_req) begin
               w_next        = S_LOCKED;
               w_settle_next = 4'd0;
            end else if (r_settle == DOOR_DELAY - 4'd1) begin
               w_next        = S_UNLOCKED;
               w_settle_next = 4'd0;
            end else begin
               w_settle_next = r_settle + 4'd1;
            end
         end
         S_UNLOCKED: begin
            if (!unlock_doors && door_closed) begin
               w_next = S_RELOCK;
            end
         end
         S_RELOCK: begin
            w_next = S_LOCKED;
         end
         default: begin
            w_next        = S_LOCKED;
            w_settle_next = 4'd0;
         end
      endcase
   end

   always_comb begin
      motion_inhibit = (r_state != S_LOCKED);
      door_alarm     = (r_state == S_UNLOCKED) && !unlock_doors && !door_closed;
   end

endmodule

// File: tb/tb_car_motion_sequencer.sv
// tb/tb_car_motion_sequencer.sv - directed vector bench for car_motion_sequencer
module tb_car_motion_sequencer;

   logic       clk;
   logic       rst;
   logic       accelerate_car;
   logic       unlock_doors;
   logic       door_closed;
   logic [7:0] car_speed;
   logic       speed_tick;
   logic       doors_unlocked;
   logic       motion_inhibit;
   logic       door_alarm;

   int total;
   int bad;

   // in = {rst, accelerate, unlock, door_closed}; fl = {tick, unlocked, inhibit, alarm}
   typedef struct packed {
      logic [3:0] in;
      logic [7:0] spd;
      logic [3:0] fl;
   } vec_t;

   vec_t vq[$];

   car_motion_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .accelerate_car (accelerate_car),
      .unlock_doors   (unlock_doors),
      .door_closed    (door_closed),
      .car_speed      (car_speed),
      .speed_tick     (speed_tick),
      .doors_unlocked (doors_unlocked),
      .motion_inhibit (motion_inhibit),
      .door_alarm     (door_alarm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic [3:0] in, input logic [7:0] spd, input logic [3:0] fl);
      vec_t v;
      v.in  = in;
      v.spd = spd;
      v.fl  = fl;
      vq.push_back(v);
   endtask

   task automatic cyc(input logic [3:0] in);
      rst            = in[3];
      accelerate_car = in[2];
      unlock_doors   = in[1];
      door_closed    = in[0];
      @(posedge clk);
      #1;
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      rst            = 1'b1;
      accelerate_car = 1'b0;
      unlock_doors   = 1'b0;
      door_closed    = 1'b1;

      // reset, then steady acceleration: tick every 4th edge, +2 per tick
      add(4'b1001, 8'd0, 4'b0000);
      add(4'b1001, 8'd0, 4'b0000);
      for (int k = 1; k <= 20; k++) begin
         add(4'b0101, 8'(2 * (k / 4)), {(k % 4 == 3), 3'b000});
      end
      add(4'b1101, 8'd0, 4'b0000);
      // standstill unlock, accelerate ignored while unlocked
      add(4'b0011, 8'd0, 4'b0010);
      add(4'b0011, 8'd0, 4'b0010);
      add(4'b0011, 8'd0, 4'b1010);
      add(4'b0011, 8'd0, 4'b0110);
      add(4'b0111, 8'd0, 4'b0110);
      add(4'b0111, 8'd0, 4'b0110);
      add(4'b0111, 8'd0, 4'b1110);
      add(4'b0111, 8'd0, 4'b0110);
      // alarm with door open, then relock and resume
      add(4'b0000, 8'd0, 4'b0111);
      add(4'b0000, 8'd0, 4'b0111);
      add(4'b0001, 8'd0, 4'b1010);
      add(4'b0101, 8'd0, 4'b0000);
      add(4'b0101, 8'd0, 4'b0000);
      add(4'b0101, 8'd0, 4'b0000);
      add(4'b0101, 8'd0, 4'b1000);
      add(4'b0101, 8'd2, 4'b0000);
      add(4'b0001, 8'd2, 4'b0000);
      add(4'b0001, 8'd2, 4'b0000);
      add(4'b0001, 8'd2, 4'b1000);
      add(4'b0001, 8'd0, 4'b0000);
      // abort at settle count 1, then full settle
      add(4'b0011, 8'd0, 4'b0010);
      add(4'b0011, 8'd0, 4'b0010);
      add(4'b0001, 8'd0, 4'b1000);
      add(4'b0011, 8'd0, 4'b0010);
      add(4'b0011, 8'd0, 4'b0010);
      add(4'b0011, 8'd0, 4'b0010);
      add(4'b0011, 8'd0, 4'b1110);
      // relock, then accelerate beats unlock in LOCKED
      add(4'b0001, 8'd0, 4'b0010);
      add(4'b0111, 8'd0, 4'b0000);
      add(4'b0111, 8'd0, 4'b0000);
      add(4'b0111, 8'd0, 4'b1000);
      add(4'b0111, 8'd2, 4'b0000);

      for (int i = 0; i < vq.size(); i++) begin
         cyc(vq[i].in);
         check8($sformatf("v%0d speed", i), car_speed, vq[i].spd);
         check1($sformatf("v%0d tick", i), speed_tick, vq[i].fl[3]);
         check1($sformatf("v%0d unlocked", i), doors_unlocked, vq[i].fl[2]);
         check1($sformatf("v%0d inhibit", i), motion_inhibit, vq[i].fl[1]);
         check1($sformatf("v%0d alarm", i), door_alarm, vq[i].fl[0]);
      end

      // saturation at 200 and decay to 0 without wrap
      cyc(4'b1001);
      check8("sat reset speed", car_speed, 8'd0);
      for (int n = 1; n <= 104; n++) begin
         repeat (4) cyc(4'b0101);
         check8($sformatf("sat up n=%0d", n), car_speed, 8'((2 * n > 200) ? 200 : 2 * n));
      end
      for (int n = 1; n <= 69; n++) begin
         repeat (4) cyc(4'b0001);
         check8($sformatf("sat down n=%0d", n), car_speed, 8'((200 - 3 * n < 0) ? 0 : 200 - 3 * n));
      end

      // reset mid-ramp in LOCKED at speed 50
      cyc(4'b1001);
      repeat (100) cyc(4'b0101);
      check8("pre-reset speed 50", car_speed, 8'd50);
      cyc(4'b1101);
      check8("rst locked speed", car_speed, 8'd0);
      check1("rst locked tick", speed_tick, 1'b0);
      check1("rst locked inhibit", motion_inhibit, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         cyc(4'b0101);
         check1($sformatf("post-rst tick k=%0d", k), speed_tick, (k == 3));
         check8($sformatf("post-rst speed k=%0d", k), car_speed, (k == 4) ? 8'd2 : 8'd0);
      end

      // reset while UNLOCKED
      cyc(4'b1011);
      for (int k = 1; k <= 4; k++) begin
         cyc(4'b0011);
         check1($sformatf("unlock latency k=%0d", k), doors_unlocked, (k == 4));
      end
      cyc(4'b1011);
      check1("rst unlocked doors", doors_unlocked, 1'b0);
      check1("rst unlocked inhibit", motion_inhibit, 1'b0);
      check1("rst unlocked alarm", door_alarm, 1'b0);
      check8("rst unlocked speed", car_speed, 8'd0);
      for (int k = 1; k <= 4; k++) begin
         cyc(4'b0101);
         check1($sformatf("post-rst2 tick k=%0d", k), speed_tick, (k == 3));
         check8($sformatf("post-rst2 speed k=%0d", k), car_speed, (k == 4) ? 8'd2 : 8'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/car_motion_sequencer.md
Name: car_motion_sequencer

Overview:
Sequences the vehicle motion and door-lock resource from the high-level car control FSM's command outputs (accelerate_car, unlock_doors).
Owns the car_speed register and integrates accelerate/decelerate commands on a prescaled tick.
Interlocks the door mechanism so doors unlock only after the car has stood still long enough, and motion is inhibited while doors are open.
car_speed feeds back to the control FSM, closing the loop.

Parameters:
MAX_SPEED, 8'd200, saturation ceiling for car_speed.
ACCEL_STEP, 8'd2, speed increment per tick while accelerating.
DECEL_STEP, 8'd3, speed decrement per tick while not accelerating.
TICK_DIV, 8'd4, clock cycles per speed update (must be ≥1).
DOOR_DELAY, 4'd3, consecutive standstill cycles required before doors unlock (must be ≥1).

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
accelerate_car  input  1  accelerate command from control FSM.
unlock_doors  input  1  door-unlock request from control FSM.
door_closed  input  1  door sensor, 1 = all doors physically closed.
car_speed  output  8  current speed, registered.
speed_tick  output  1  one-cycle pulse on the cycle car_speed updates.
doors_unlocked  output  1  door actuator, 1 = unlocked; registered.
motion_inhibit  output  1  1 while the door FSM is not in LOCKED.
door_alarm  output  1  1 while UNLOCKED, unlock_doors = 0 and door_closed = 0.

Behaviour:
- Reset (rst=1 at a clock edge, any state, mid-ramp included): car_speed=0, prescaler=0, speed_tick=0, door FSM=LOCKED, settle counter=0, doors_unlocked=0, motion_inhibit=0, door_alarm=0.
- Prescaler: counts 0..TICK_DIV-1 and wraps; free-running outside reset. speed_tick=1 for exactly the cycle in which prescaler==TICK_DIV-1. car_speed updates on that same edge.
- Speed update at tick, in priority order:
  - motion_inhibit=1: car_speed holds.
  - accelerate_car=1: car_speed = min(car_speed+ACCEL_STEP, MAX_SPEED). Compute the sum 9 bits wide; never wrap.
  - Otherwise: car_speed = (car_speed > DECEL_STEP) ? car_speed-DECEL_STEP : 0. Never underflow.
  - Between ticks, car_speed holds.
- Door FSM states: LOCKED, SETTLE, UNLOCKED, RELOCK.
  - LOCKED: if car_speed==0, unlock_doors=1 and accelerate_car=0, go to SETTLE with settle counter=0.
  - SETTLE: each cycle, if car_speed==0, unlock_doors=1 and accelerate_car=0, increment the counter. When the counter reaches DOOR_DELAY-1, go to UNLOCKED. Any condition false returns to LOCKED (abort; counter cleared).
  - UNLOCKED: doors_unlocked=1. When unlock_doors=0 and door_closed=1, go to RELOCK.
  - RELOCK: doors_unlocked=0 for one cycle, then unconditionally go to LOCKED.
- Outputs:
  - doors_unlocked=1 only in UNLOCKED; it is registered with the state, so it asserts the cycle after entry.
  - motion_inhibit=1 in SETTLE, UNLOCKED and RELOCK.
  - door_alarm is combinational from state and inputs.
- Simultaneous events:
  - accelerate_car and unlock_doors both 1: accelerate wins; door FSM stays or returns to LOCKED.
  - Tick coinciding with the SETTLE entry: car_speed already 0, no change.
  - accelerate_car=1 while UNLOCKED: ignored; speed stays 0.
- Latency: unlock_doors rising at standstill -> doors_unlocked=1 after DOOR_DELAY+1 edges. RELOCK->LOCKED takes 1 cycle, after which motion resumes at the next tick.

Test Plan:
1. Defaults; rst 2 cycles, then accelerate_car=1 for 20 cycles -> speed_tick every 4th cycle; car_speed 2,4,6,8,10; no change between ticks.
2. Saturation: reach car_speed=198, hold accelerate_car=1 -> next tick 200, stays 200, never wraps. Release accelerate_car -> 197,194,… down to 2, then 0 (not 255). Stays 0.
3. Standstill unlock: car_speed=0, unlock_doors=1 -> SETTLE for 3 cycles, doors_unlocked=1 on the 4th edge, motion_inhibit=1 from the first edge. Pulse accelerate_car while UNLOCKED -> car_speed stays 0.
4. Abort: in SETTLE at count 1, drop unlock_doors -> back to LOCKED, doors_unlocked never asserts, counter cleared. Reassert -> full 3-cycle settle again.
5. Relock and alarm: in UNLOCKED, unlock_doors=0 with door_closed=0 -> door_alarm=1, doors stay unlocked. Then door_closed=1 -> RELOCK for 1 cycle, LOCKED, alarm=0, motion_inhibit=0; acceleration resumes at the next tick.
6. Reset mid-operation: rst=1 at car_speed=50 in LOCKED, and separately in UNLOCKED -> next edge: car_speed=0, doors_unlocked=0, prescaler=0. First tick after release occurs 4 cycles later.
